sprite_motion_controller: RTL and testbench

Frame-synchronous controller that owns the position of the single square sprite overlaid on the VGA image. It debounces the four direction buttons and detects frame boundaries from the timing generator's screenEnd. It commits exactly one accelerated, clamped position update per frame and produces a registered per-pixel sprite-hit flag for the colour mux. It sits between the board buttons, the VGA timing generator and the output colour select.

---
 rtl/sprite_motion_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_sprite_motion_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_controller.sv
// sprite_motion_controller
// ------------------------
// This module owns the position of one square sprite that is drawn over the VGA
// image. It does four jobs:
//   - It synchronises and debounces the four direction buttons.
//   - It turns the timing generator's screenEnd into a one-cycle frame tick.
//   - It commits one accelerated position update per frame tick.
//   - It produces a registered per-pixel hit flag for the colour mux.
//
// Ports:
//   clk        system clock; all logic runs on its rising edge
//   reset      synchronous reset, active low
//   up/down/left/right
//              raw, asynchronous push buttons
//   screenEnd  end-of-frame strobe from the pixel-clock domain
//   x, y       current pixel coordinate from the timing generator
//   spriteX    sprite left edge; changes only on the cycle after frameTick
//   spriteY    sprite top edge; changes only on the cycle after frameTick
//   inSprite   registered: pixel (x,y) lies inside the sprite (1-cycle latency)
//   frameTick  one-cycle pulse per frame
//
// Build option:
//   SPRITE_WRAP_EN  when defined, the position wraps around the screen edges
//                   instead of clamping to them.
//
// Motion FSM (moves only on frameTick)
//   state    | meaning
//   S_IDLE   | no button held; step=1, holdCnt=0
//   S_RAMP   | button held; step grows by 1 every ACCEL_FRAMES frames
//   S_CRUISE | button held; step has reached MAX_STEP

module sprite_motion_controller #(
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int SPRITE_SIZE     = 50,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_STEP        = 4,
    parameter int ACCEL_FRAMES    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       screenEnd,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic [9:0] spriteX,
    output logic [8:0] spriteY,
    output logic       inSprite,
    output logic       frameTick
);

    localparam int X_MAX  = SCREEN_W - SPRITE_SIZE;
    localparam int Y_MAX  = SCREEN_H - SPRITE_SIZE;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int STEP_W = $clog2(MAX_STEP + 1);
    localparam int HOLD_W = $clog2(ACCEL_FRAMES + 1);

    localparam logic [9:0]         X_HOME    = 10'(X_MAX / 2);
    localparam logic [8:0]         Y_HOME    = 9'(Y_MAX / 2);
    localparam logic signed [10:0] X_LIM     = 11'(X_MAX);
    localparam logic signed [10:0] Y_LIM     = 11'(Y_MAX);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0]  STEP_MAX  = STEP_W'(MAX_STEP);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(ACCEL_FRAMES - 1);
    localparam logic [10:0]        SIZE_11   = 11'(SPRITE_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_RAMP, S_CRUISE} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    // Bit order of the button vectors: [3]=up, [2]=down, [1]=left, [0]=right.
    logic [3:0]       btn_raw, btn_s1, btn_s2, btn_db;
    logic [CNT_W-1:0] db_cnt [4];

    logic se_s1, se_s2, se_s3;

    state_t             state, state_nxt;
    dir_t               dir_q, dir_nxt, sel_dir;
    logic [STEP_W-1:0]  step_q, step_nxt, step_eff, step_inc;
    logic [HOLD_W-1:0]  hold_q, hold_nxt, hold_eff;
    logic               any_btn, fresh, ramp_up, move;

    logic signed [10:0] cur_x, cur_y, delta, nx, ny;
    logic [9:0]         x_new;
    logic [8:0]         y_new;

    assign btn_raw = {up, down, left, right};

    // The counter only runs while the synced value and the debounced value
    // disagree. Any bounce back to agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_db <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_cnt[i] <= '0;
                    btn_db[i] <= btn_s2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // The frame tick is registered after the edge detector. It rises on the
    // third clk edge after screenEnd is first sampled high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            se_s1     <= 1'b0;
            se_s2     <= 1'b0;
            se_s3     <= 1'b0;
            frameTick <= 1'b0;
        end else begin
            se_s1     <= screenEnd;
            se_s2     <= se_s1;
            se_s3     <= se_s2;
            frameTick <= se_s2 & ~se_s3;
        end
    end

    always_comb begin
        any_btn = |btn_db;
        if (btn_db[3])      sel_dir = D_UP;
        else if (btn_db[2]) sel_dir = D_DOWN;
        else if (btn_db[1]) sel_dir = D_LEFT;
        else                sel_dir = D_RIGHT;
    end

    // A frame that starts a new hold, or that changes direction, restarts the
    // ramp. That frame moves by 1, and it counts as the first held frame.
    always_comb begin
        fresh    = (state == S_IDLE) || (sel_dir != dir_q);
        step_eff = fresh ? STEP_ONE : step_q;
        hold_eff = fresh ? '0 : hold_q;
        ramp_up  = (hold_eff == HOLD_LAST);
        step_inc = (ramp_up && (step_eff < STEP_MAX)) ? step_eff + STEP_ONE : step_eff;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            dir_q  <= D_UP;
            step_q <= STEP_ONE;
            hold_q <= '0;
        end else begin
            state  <= state_nxt;
            dir_q  <= dir_nxt;
            step_q <= step_nxt;
            hold_q <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (frameTick) begin
            if (!any_btn)                state_nxt = S_IDLE;
            else if (step_inc >= STEP_MAX) state_nxt = S_CRUISE;
            else                         state_nxt = S_RAMP;
        end
    end

    always_comb begin
        dir_nxt  = dir_q;
        step_nxt = step_q;
        hold_nxt = hold_q;
        move     = frameTick && any_btn;
        if (frameTick) begin
            if (!any_btn) begin
                step_nxt = STEP_ONE;
                hold_nxt = '0;
            end else begin
                dir_nxt  = sel_dir;
                step_nxt = step_inc;
                hold_nxt = (ramp_up || state_nxt == S_CRUISE) ? '0 : hold_eff + HOLD_W'(1);
            end
        end
    end

    function automatic logic [9:0] fit(input logic signed [10:0] v,
                                       input logic signed [10:0] lim);
`ifdef SPRITE_WRAP_EN
        if (v < 0)        return 10'(v + lim + 11'sd1);
        else if (v > lim) return 10'(v - lim - 11'sd1);
        else              return 10'(v);
`else
        if (v < 0)        return '0;
        else if (v > lim) return 10'(lim);
        else              return 10'(v);
`endif
    endfunction

    // The new position is computed in 11-bit signed arithmetic, so a step
    // past the left or top edge shows up as a negative value.
    always_comb begin
        cur_x = signed'({1'b0, spriteX});
        cur_y = signed'({2'b0, spriteY});
        delta = signed'(11'(step_eff));
        nx    = cur_x;
        ny    = cur_y;
        case (sel_dir)
            D_UP:    ny = cur_y - delta;
            D_DOWN:  ny = cur_y + delta;
            D_LEFT:  nx = cur_x - delta;
            default: nx = cur_x + delta;
        endcase
        x_new = fit(nx, X_LIM);
        y_new = 9'(fit(ny, Y_LIM));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            spriteX <= X_HOME;
            spriteY <= Y_HOME;
        end else if (move) begin
            spriteX <= x_new;
            spriteY <= y_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            inSprite <= 1'b0;
        end else begin
            inSprite <= ({1'b0, x} >= {1'b0, spriteX}) &&
                        ({1'b0, x} <  ({1'b0, spriteX} + SIZE_11)) &&
                        ({2'b0, y} >= {2'b0, spriteY}) &&
                        ({2'b0, y} <  ({2'b0, spriteY} + SIZE_11));
        end
    end

endmodule

// File: tb/tb_sprite_motion_controller.sv
// Directed bench for sprite_motion_controller. It uses a short debounce
// (4 cycles), a fast ramp (2 frames per step increment) and MAX_STEP=4.
module tb_sprite_motion_controller;

    logic       clk = 1'b0;
    logic       reset, up, down, left, right, screenEnd;
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] spriteX;
    logic [8:0] spriteY;
    logic       inSprite, frameTick;

    int total = 0;
    int bad   = 0;
    int lat, width;

    int exp_r  [10] = '{296, 297, 299, 301, 304, 307, 311, 315, 319, 323};
    int exp_ud [3]  = '{214, 213, 211};

    always #5 clk = ~clk;

    sprite_motion_controller #(
        .DEBOUNCE_CYCLES(4),
        .ACCEL_FRAMES   (2),
        .MAX_STEP       (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .screenEnd(screenEnd),
        .x        (x),
        .y        (y),
        .spriteX  (spriteX),
        .spriteY  (spriteY),
        .inSprite (inSprite),
        .frameTick(frameTick)
    );

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame lasts 12 cycles. It reports how many cycles pass before
    // frameTick first rises, and for how many cycles frameTick stays high.
    task automatic frame(output int l, output int w);
        l = 0;
        w = 0;
        screenEnd = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) screenEnd = 1'b0;
            if (frameTick === 1'b1) begin
                if (w == 0) l = i;
                w++;
            end
        end
    endtask

    initial begin
        reset = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        screenEnd = 1'b0; x = '0; y = '0;
        step_clk(2);
        reset = 1'b1;
        step_clk(1);
        chk("rst_x", 32'(spriteX), 295);
        chk("rst_y", 32'(spriteY), 215);
        chk("rst_in", 32'(inSprite), 0);
        chk("rst_tick", 32'(frameTick), 0);

        frame(lat, width);
        chk("tick_latency", lat, 3);
        chk("tick_width", width, 1);
        chk("idle_x", 32'(spriteX), 295);

        right = 1'b1;
        step_clk(10);
        for (int i = 0; i < 10; i++) begin
            frame(lat, width);
            chk($sformatf("right_f%0d", i), 32'(spriteX), exp_r[i]);
        end
        chk("right_y", 32'(spriteY), 215);
        right = 1'b0;
        step_clk(10);
        frame(lat, width);
        chk("release_x", 32'(spriteX), 323);

        up = 1'b1;
        step_clk(2);
        up = 1'b0;
        frame(lat, width);
        frame(lat, width);
        chk("glitch_y", 32'(spriteY), 215);

        up = 1'b1;
        down = 1'b1;
        step_clk(10);
        for (int i = 0; i < 3; i++) begin
            frame(lat, width);
            chk($sformatf("updown_f%0d", i), 32'(spriteY), exp_ud[i]);
        end
        chk("updown_x", 32'(spriteX), 323);
        up = 1'b0;
        down = 1'b0;
        step_clk(10);
        frame(lat, width);

`ifndef SPRITE_WRAP_EN
        left = 1'b1;
        step_clk(10);
        repeat (90) frame(lat, width);
        chk("edge_x", 32'(spriteX), 0);
        frame(lat, width);
        frame(lat, width);
        chk("edge_hold_x", 32'(spriteX), 0);
        chk("edge_y", 32'(spriteY), 211);
        left = 1'b0;
        step_clk(10);
        frame(lat, width);
`endif

        reset = 1'b0;
        step_clk(2);
        reset = 1'b1;
        x = 10'd295;
        y = 9'd215;
        step_clk(1);
        chk("hit_corner", 32'(inSprite), 1);
        x = 10'd345;
        step_clk(1);
        chk("miss_right", 32'(inSprite), 0);
        x = 10'd344;
        y = 9'd264;
        step_clk(1);
        chk("hit_far_corner", 32'(inSprite), 1);
        x = 10'd294;
        step_clk(1);
        chk("miss_left", 32'(inSprite), 0);
        x = 10'd300;
        y = 9'd265;
        step_clk(1);
        chk("miss_below", 32'(inSprite), 0);

        right = 1'b1;
        step_clk(10);
        repeat (3) frame(lat, width);
        chk("ramp_x", 32'(spriteX), 299);
        reset = 1'b0;
        step_clk(2);
        reset = 1'b1;
        step_clk(1);
        chk("midreset_x", 32'(spriteX), 295);
        step_clk(10);
        frame(lat, width);
        chk("after_reset_f0", 32'(spriteX), 296);
        frame(lat, width);
        chk("after_reset_f1", 32'(spriteX), 297);
        right = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
